nes_loader: RTL and testbench

Avalon-MM write initiator that drives the NES command/write slave from the FPGA fabric side. It accepts a load request (base address, byte count), resets and pauses the NES CPU, streams program bytes from a valid/ready byte source into NES memory with WRITE_MEM commands, then optionally issues START_CPU. It replaces HPS software poking the slave, giving a hardware path for boot-ROM and test-image loading.

---
 rtl/nes_pkg.sv | 17 +
 rtl/nes_loader_slot.sv | 37 +++
 rtl/nes_loader.sv | 135 +++++++++++++
 tb/tb_nes_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES command definitions: slave opcodes and the loader state encoding.
package nes_pkg;

   localparam logic [7:0] OP_RESET_CPU = 8'h00;
   localparam logic [7:0] OP_START_CPU = 8'h01;
   localparam logic [7:0] OP_PAUSE_CPU = 8'h02;
   localparam logic [7:0] OP_WRITE_MEM = 8'h03;

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_PSE, S_LOAD, S_GO, S_ABT
   } ld_state_t;

   function automatic logic [15:0] nes_cmd(input logic [7:0] op, input logic [7:0] data);
      return {op, data};
   endfunction

endpackage

// File: rtl/nes_loader_slot.sv
// Single-entry Avalon-MM write holding register; address/data persist between writes
// because the NES slave decodes writedata every cycle.
module nes_avm_wr_slot
   import nes_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] ld_address,
   input  logic [15:0] ld_writedata,
   input  logic        m_waitrequest,
   output logic        m_write,
   output logic        m_chipselect,
   output logic [15:0] m_address,
   output logic [15:0] m_writedata,
   output logic        slot_free
);

   // free when empty or when the held write completes this cycle
   assign slot_free    = !m_write || !m_waitrequest;
   assign m_chipselect = m_write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_write     <= 1'b0;
         m_address   <= 16'h0000;
         m_writedata <= nes_cmd(OP_PAUSE_CPU, 8'h00);
      end else if (load) begin
         m_write     <= 1'b1;
         m_address   <= ld_address;
         m_writedata <= ld_writedata;
      end else if (m_write && !m_waitrequest) begin
         m_write     <= 1'b0;
      end
   end

endmodule

// File: rtl/nes_loader.sv
// Fabric-side NES program loader: RESET, PAUSE, WRITE_MEM per byte, optional START,
// with an abort path that always leaves the CPU paused.
module nes_loader
   import nes_pkg::*;
#(
   parameter bit AUTO_START = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] base_addr,
   input  logic [15:0] length,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [15:0] m_address,
   output logic [15:0] m_writedata,
   output logic        m_write,
   output logic        m_chipselect,
   input  logic        m_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        aborted
);

   ld_state_t   state_q, state_d;
   logic [15:0] rem_q, ptr_q, base_q;
   logic        slot_free, ld, done_d, abrt_d, accept;
   logic [15:0] ld_addr, ld_wdata;

   assign busy   = (state_q != S_IDLE);
   assign accept = in_ready && in_valid;

   // state names the write currently held in the slot; the next write is
   // loaded on the same edge the current one completes
   always_comb begin
      state_d  = state_q;
      ld       = 1'b0;
      ld_addr  = base_q;
      ld_wdata = nes_cmd(OP_PAUSE_CPU, 8'h00);
      in_ready = 1'b0;
      done_d   = 1'b0;
      abrt_d   = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            ld       = 1'b1;
            ld_addr  = base_addr;
            ld_wdata = nes_cmd(OP_RESET_CPU, 8'h00);
            state_d  = S_RST;
         end
         S_RST: if (slot_free) begin
            ld      = 1'b1;
            state_d = abort ? S_ABT : S_PSE;
         end
         S_PSE, S_LOAD: begin
            if (abort) begin
               if (slot_free) begin
                  ld      = 1'b1;
                  state_d = S_ABT;
               end
            end else if (rem_q != 16'd0) begin
               in_ready = slot_free;
               if (slot_free) state_d = S_LOAD;
               if (slot_free && in_valid) begin
                  ld       = 1'b1;
                  ld_addr  = ptr_q;
                  ld_wdata = nes_cmd(OP_WRITE_MEM, in_data);
               end
            end else if (slot_free) begin
               if (AUTO_START) begin
                  ld       = 1'b1;
                  ld_wdata = nes_cmd(OP_START_CPU, 8'h00);
                  state_d  = S_GO;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_GO: if (slot_free) begin
            if (abort) begin
               ld      = 1'b1;
               state_d = S_ABT;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_ABT: if (slot_free) begin
            state_d = S_IDLE;
            abrt_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rem_q   <= 16'd0;
         ptr_q   <= 16'd0;
         base_q  <= 16'd0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= done_d;
         aborted <= abrt_d;
         if (state_q == S_IDLE && start) begin
            rem_q  <= length;
            ptr_q  <= base_addr;
            base_q <= base_addr;
         end else if (accept) begin
            rem_q <= rem_q - 16'd1;
            ptr_q <= ptr_q + 16'd1;
         end
      end
   end

   nes_avm_wr_slot u_slot (
      .clk          (clk),
      .reset_n      (reset_n),
      .load         (ld),
      .ld_address   (ld_addr),
      .ld_writedata (ld_wdata),
      .m_waitrequest(m_waitrequest),
      .m_write      (m_write),
      .m_chipselect (m_chipselect),
      .m_address    (m_address),
      .m_writedata  (m_writedata),
      .slot_free    (slot_free)
   );

endmodule

// File: tb/tb_nes_loader.sv
// Directed bench for nes_loader: write-log scoreboard, stall hold monitor, cycle checks.
module tb_nes_loader;
   import nes_pkg::*;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        start0 = 1'b0, start1 = 1'b0, abort = 1'b0;
   logic [15:0] base_addr = '0, length = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        stall_mode = 1'b0, stall_wr = 1'b0, man_wr = 1'b0;
   logic        m_waitrequest;
   logic        in_ready, m_write, m_chipselect, busy, done0, aborted0;
   logic [15:0] m_address, m_writedata;
   logic        in_ready1, m_write1, m_cs1, busy1, done1, aborted1;
   logic [15:0] m_address1, m_writedata1;

   int nvec = 0, nfail = 0;
   int cyc = 0, acc_cnt = 0, src_base = 0, src_n = 0;
   int done_cnt = 0, abt_cnt = 0, done_cyc = 0, abt_cyc = 0;
   logic        gap_mode = 1'b0;
   logic [7:0]  src_mem [16];
   logic [31:0] wlog[$], expq[$];
   logic        prev_stall = 1'b0;
   logic [31:0] ps_word = '0;

   assign m_waitrequest = stall_mode ? stall_wr : man_wr;

   always #5 clk = ~clk;

   nes_loader #(.AUTO_START(1'b1)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .base_addr(base_addr), .length(length),
      .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write),
      .m_chipselect(m_chipselect), .m_waitrequest(m_waitrequest),
      .busy(busy), .done(done0), .aborted(aborted0));

   nes_loader #(.AUTO_START(1'b0)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .base_addr(base_addr), .length(length),
      .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
      .m_address(m_address1), .m_writedata(m_writedata1), .m_write(m_write1),
      .m_chipselect(m_cs1), .m_waitrequest(m_waitrequest),
      .busy(busy1), .done(done1), .aborted(aborted1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // write log and handshake bookkeeping, sampled on the active edge before update
   always @(posedge clk) begin
      if (reset_n) begin
         if (prev_stall) begin
            chk("stall m_write", {31'd0, m_write}, 32'd1);
            chk("stall hold", {m_address, m_writedata}, ps_word);
         end
         prev_stall = m_write && m_waitrequest;
         ps_word    = {m_address, m_writedata};
         if (m_write && !m_waitrequest) wlog.push_back({m_address, m_writedata});
         if (in_valid && in_ready) acc_cnt++;
         if (done0)    begin done_cnt++; done_cyc = cyc; end
         if (aborted0) begin abt_cnt++;  abt_cyc  = cyc; end
      end else begin
         prev_stall = 1'b0;
      end
      cyc++;
   end

   // byte source and 3-cycle-per-write stall generator
   initial begin
      int idx, scnt;
      scnt = 0;
      forever begin
         @(negedge clk);
         idx      = acc_cnt - src_base;
         in_valid = (idx < src_n) && (!gap_mode || cyc[0]);
         in_data  = (idx >= 0 && idx < 16) ? src_mem[idx] : 8'h00;
         if (m_write && scnt < 3) begin stall_wr = 1'b1; scnt++; end
         else begin stall_wr = 1'b0; scnt = 0; end
      end
   end

   task automatic do_start(input logic [15:0] b, input logic [15:0] n, input bit which, output int s);
      @(negedge clk);
      s = cyc; base_addr = b; length = n;
      if (which) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
   endtask

   task automatic wait_end(input int dc0, input int ac0);
      int k;
      k = 0;
      while (done_cnt == dc0 && abt_cnt == ac0 && k < 300) begin @(negedge clk); k++; end
      chk("completion timeout", {31'd0, k < 300}, 32'd1);
   endtask

   task automatic new_run(input int n);
      wlog.delete(); expq.delete();
      src_base = acc_cnt; src_n = n;
   endtask

   task automatic ex(input logic [15:0] a, input logic [15:0] d);
      expq.push_back({a, d});
   endtask

   // address is only specified for RESET and WRITE_MEM writes
   task automatic cmp_log(input string tag);
      chk({tag, " count"}, wlog.size(), expq.size());
      for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
         if (expq[i][15:8] == OP_WRITE_MEM || expq[i][15:8] == OP_RESET_CPU)
            chk($sformatf("%s w%0d", tag, i), wlog[i], expq[i]);
         else
            chk($sformatf("%s w%0d", tag, i), {16'h0, wlog[i][15:0]}, {16'h0, expq[i][15:0]});
      end
   endtask

   task automatic normal_load(input string tag);
      int s, dc;
      src_mem[0] = 8'hA9; src_mem[1] = 8'h01; src_mem[2] = 8'h8D; src_mem[3] = 8'h00;
      new_run(4);
      ex(16'h8000, 16'h0000); ex(16'h8000, 16'h0200);
      ex(16'h8000, 16'h03A9); ex(16'h8001, 16'h0301); ex(16'h8002, 16'h038D); ex(16'h8003, 16'h0300);
      ex(16'h8000, 16'h0100);
      dc = done_cnt;
      do_start(16'h8000, 16'd4, 1'b0, s);
      wait_end(dc, abt_cnt);
      cmp_log(tag);
      chk({tag, " done cycle"}, done_cyc - s, (stall_mode ? 32'd29 : 32'd8));
      chk({tag, " bytes taken"}, acc_cnt - src_base, 32'd4);
   endtask

   initial begin
      int s, dc, ac;
      for (int i = 0; i < 16; i++) src_mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset wdata", {16'h0, m_writedata}, 32'h0200);
      chk("reset addr",  {16'h0, m_address}, 32'h0);
      chk("reset outs",  {26'd0, m_write, m_chipselect, in_ready, busy, done0, aborted0}, 32'd0);
      reset_n = 1'b1;

      // normal load, no stalls
      normal_load("normal");
      @(negedge clk);
      chk("idle busy", {31'd0, busy}, 32'd0);
      chk("idle wdata hold", {16'h0, m_writedata}, 32'h0100);

      // every write stalled three cycles
      stall_mode = 1'b1;
      normal_load("stall");
      stall_mode = 1'b0;

      // source gaps and address wrap
      gap_mode = 1'b1;
      src_mem[0] = 8'h11; src_mem[1] = 8'h22; src_mem[2] = 8'h33;
      new_run(3);
      ex(16'hFFFE, 16'h0000); ex(16'hFFFE, 16'h0200);
      ex(16'hFFFE, 16'h0311); ex(16'hFFFF, 16'h0322); ex(16'h0000, 16'h0333); ex(16'h0000, 16'h0100);
      dc = done_cnt;
      do_start(16'hFFFE, 16'd3, 1'b0, s);
      wait_end(dc, abt_cnt);
      cmp_log("wrap");
      gap_mode = 1'b0;

      // length 0 with START
      new_run(0);
      ex(16'h1234, 16'h0000); ex(16'h1234, 16'h0200); ex(16'h1234, 16'h0100);
      dc = done_cnt;
      do_start(16'h1234, 16'd0, 1'b0, s);
      wait_end(dc, abt_cnt);
      cmp_log("len0 auto");
      chk("len0 auto done cycle", done_cyc - s, 32'd4);

      // length 0 without START (second instance)
      do_start(16'h1234, 16'd0, 1'b1, s);
      chk("noauto c1", {15'd0, m_write1, m_writedata1}, {15'd0, 1'b1, 16'h0000});
      chk("noauto c1 addr", {16'h0, m_address1}, 32'h1234);
      @(negedge clk);
      chk("noauto c2", {15'd0, m_write1, m_writedata1}, {15'd0, 1'b1, 16'h0200});
      @(negedge clk);
      chk("noauto c3", {13'd0, m_write1, done1, busy1, m_writedata1}, {13'd0, 3'b010, 16'h0200});
      @(negedge clk);
      chk("noauto c4", {14'd0, done1, m_write1, m_writedata1}, {14'd0, 2'b00, 16'h0200});

      // abort after byte 2 of 8 while its write is stalled
      for (int i = 0; i < 8; i++) src_mem[i] = 8'h10 + 8'(i);
      new_run(8);
      ex(16'h2000, 16'h0000); ex(16'h2000, 16'h0200);
      ex(16'h2000, 16'h0310); ex(16'h2001, 16'h0311); ex(16'h2002, 16'h0312); ex(16'h2000, 16'h0200);
      dc = done_cnt; ac = abt_cnt;
      do_start(16'h2000, 16'd8, 1'b0, s);
      repeat (4) @(negedge clk);
      man_wr = 1'b1; abort = 1'b1;
      #1;
      chk("abort in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort held write", {m_address, m_writedata}, {16'h2002, 16'h0312});
      @(negedge clk);
      man_wr = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      wait_end(dc, ac);
      cmp_log("abort");
      chk("abort pulse cycle", abt_cyc - s, 32'd8);
      chk("abort no done", done_cnt - dc, 32'd0);
      chk("abort bytes taken", acc_cnt - src_base, 32'd3);
      @(negedge clk);
      chk("abort pulse width", {31'd0, aborted0}, 32'd0);

      // abort in IDLE is ignored; start coincident with abort wins
      new_run(0);
      ex(16'h3000, 16'h0000); ex(16'h3000, 16'h0200);
      ac = abt_cnt; dc = done_cnt;
      abort = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle abort", {29'd0, busy, m_write, aborted0}, 32'd0);
      do_start(16'h3000, 16'd0, 1'b0, s);
      wait_end(dc, ac);
      abort = 1'b0;
      cmp_log("start+abort");
      chk("start+abort pulse", abt_cnt - ac, 32'd1);

      // async reset mid-LOAD, then a clean load
      new_run(8);
      do_start(16'h4000, 16'd8, 1'b0, s);
      repeat (3) @(negedge clk);
      chk("pre-reset write", {31'd0, m_write}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("reset mid wdata", {16'h0, m_writedata}, 32'h0200);
      chk("reset mid outs", {28'd0, m_write, in_ready, busy, done0}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      normal_load("post-reset");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
